// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 command codes, FSM state encoding and frame helper.
package ps2_pkg;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RESP_ACK = 8'hFA;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_REQ = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_ACK = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    INHIBIT = ST_INHIBIT,
    REQ = ST_REQ,
    SEND = ST_SEND,
    ACK = ST_ACK,
    WAIT_IDLE = ST_WAIT_IDLE
  } state_t;
  // Indices 0..7 carry data LSB first, index 8 the odd parity bit.
  function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
    return idx < 4'd8 ? d[idx[2:0]] : ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchronizes the PS2Clk/PS2Data pair and strobes on clock falls.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);
  logic [SYNC_STAGES-1:0] c_sr, d_sr;
  logic c_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_sr <= '1;
      d_sr <= '1;
      c_q <= 1'b1;
    end else begin
      c_sr <= {c_sr[SYNC_STAGES-2:0], ps2_clk_in};
      d_sr <= {d_sr[SYNC_STAGES-2:0], ps2_data_in};
      c_q <= c_sr[SYNC_STAGES-1];
    end
  end
  assign clk_s = c_sr[SYNC_STAGES-1];
  assign data_s = d_sr[SYNC_STAGES-1];
  assign clk_fall = c_q & ~clk_s;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter over open-drain clock/data.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);
  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  state_t state;
  logic [7:0] data_q;
  logic [3:0] bit_idx;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic clk_s, data_s, clk_fall, timed_out;
  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_s(clk_s),
    .data_s(data_s),
    .clk_fall(clk_fall)
  );
  assign tx_ready = state == IDLE;
  assign timed_out = state inside {REQ, SEND, ACK, WAIT_IDLE} && !clk_fall
                     && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      data_q <= '0;
      bit_idx <= '0;
      inh_cnt <= '0;
      tmo_cnt <= '0;
      busy <= 1'b0;
      tx_done <= 1'b0;
      tx_error <= 1'b0;
      ps2_clk_drive_low <= 1'b0;
      ps2_data_drive_low <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_error <= 1'b0;
      tmo_cnt <= clk_fall ? '0 : tmo_cnt + 1'b1;
      if (timed_out) begin
        state <= IDLE;
        busy <= 1'b0;
        tx_error <= 1'b1;
        ps2_clk_drive_low <= 1'b0;
        ps2_data_drive_low <= 1'b0;
      end else begin
        case (state)
          IDLE: if (tx_valid) begin
            data_q <= tx_data;
            busy <= 1'b1;
            inh_cnt <= '0;
            ps2_clk_drive_low <= 1'b1;
            state <= INHIBIT;
          end
          // Start bit goes low in the last inhibit cycle so data is low before clock release.
          INHIBIT: begin
            inh_cnt <= inh_cnt + 1'b1;
            if (inh_cnt == IW'(INHIBIT_CYCLES - 2)) ps2_data_drive_low <= 1'b1;
            if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
              ps2_clk_drive_low <= 1'b0;
              state <= REQ;
            end
          end
          REQ: begin
            tmo_cnt <= '0;
            bit_idx <= '0;
            state <= SEND;
          end
          SEND: if (clk_fall) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 4'd9) begin
              ps2_data_drive_low <= 1'b0;
              state <= ACK;
            end else ps2_data_drive_low <= ~frame_bit(data_q, bit_idx);
          end
          ACK: if (clk_fall) begin
            if (data_s) begin
              tx_error <= 1'b1;
              busy <= 1'b0;
              state <= IDLE;
            end else state <= WAIT_IDLE;
          end
          WAIT_IDLE: if (clk_s && data_s) begin
            tx_done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed scenarios against a clocking PS/2 device model on wired-AND lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int INH = 40, TMO = 300, SYNC = 2, H = 10;
  logic clk = 1'b0, rst_n = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, tx_done, tx_error, busy, clk_dl, data_dl;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic ps2_clk_in, ps2_data_in;
  int vectors = 0, miscompares = 0, cyc = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0, last_fall = 0;
  logic pulse_ready = 1'b0, pulse_busy = 1'b1;

  assign ps2_clk_in = dev_clk & ~clk_dl;
  assign ps2_data_in = dev_data & ~data_dl;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_drive_low(clk_dl), .ps2_data_drive_low(data_dl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (tx_done) done_cnt++;
    if (tx_error) begin err_cnt++; err_cyc = cyc; end
    if (tx_done || tx_error) begin pulse_ready = tx_ready; pulse_busy = busy; end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got cycle %0d expected < 100000", cyc);
    $fatal(1);
  end

  task automatic device(input logic ack, input int nfalls, output logic [10:0] got,
                        output int inh_len, output logic pre_data, output logic start_bit);
    int t0;
    got = '1; inh_len = 0; pre_data = 1'b0; start_bit = 1'b1;
    for (int i = 0; i < 50 && !clk_dl; i++) @(negedge clk);
    if (!clk_dl) return;
    t0 = cyc;
    while (clk_dl && cyc - t0 < INH + 20) begin
      pre_data = data_dl;
      @(negedge clk);
    end
    inh_len = cyc - t0;
    start_bit = ps2_data_in;
    repeat (H) @(negedge clk);
    for (int k = 0; k < nfalls; k++) begin
      dev_clk = 1'b0;
      last_fall = cyc;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      got[k] = ps2_data_in;
      if (k == 9) dev_data = ack;
      repeat (H) @(negedge clk);
      if (k == 10) dev_data = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic ack, input int nfalls, output logic [10:0] got,
                      output int inh, output logic pd, output logic sb);
    fork
      begin tx_valid = 1'b1; tx_data = b; @(negedge clk); tx_valid = 1'b0; end
      device(ack, nfalls, got, inh, pd, sb);
    join
  endtask

  task automatic wait_pulse(input int d0, input int e0);
    for (int i = 0; i < TMO + 100 && done_cnt + err_cnt == d0 + e0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
    vectors++; if ({busy, tx_done, tx_error} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {busy, tx_done, tx_error}); end
    vectors++; if ({clk_dl, data_dl} !== 2'b00) begin miscompares++; $display("FAIL reset_drive: got %b expected 00", {clk_dl, data_dl}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_set_leds;
    logic [10:0] got; int inh; logic pd, sb;
    int d0 = done_cnt, e0 = err_cnt;
    send(CMD_SET_LEDS, 1'b0, 11, got, inh, pd, sb);
    vectors++; if (got[9:0] !== 10'b1_1_11101101) begin miscompares++; $display("FAIL leds_frame: got %b expected 1111101101", got[9:0]); end
    wait_pulse(d0, e0);
    vectors++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL leds_result: got done=%0d err=%0d expected done=1 err=0", done_cnt - d0, err_cnt - e0); end
    vectors++; if (pulse_ready !== 1'b1 || pulse_busy !== 1'b0) begin miscompares++; $display("FAIL leds_pulse: got ready=%b busy=%b expected ready=1 busy=0", pulse_ready, pulse_busy); end
    vectors++; if ({busy, clk_dl, data_dl} !== 3'b000) begin miscompares++; $display("FAIL leds_after: got %b expected 000", {busy, clk_dl, data_dl}); end
  endtask

  task automatic test_enable;
    logic [10:0] got; int inh; logic pd, sb;
    int d0 = done_cnt, e0 = err_cnt;
    send(CMD_ENABLE, 1'b0, 11, got, inh, pd, sb);
    vectors++; if (inh !== INH) begin miscompares++; $display("FAIL enable_inhibit: got %0d expected %0d", inh, INH); end
    vectors++; if (pd !== 1'b1) begin miscompares++; $display("FAIL enable_data_before_release: got %b expected 1", pd); end
    vectors++; if (sb !== 1'b0) begin miscompares++; $display("FAIL enable_start_bit: got %b expected 0", sb); end
    vectors++; if (got[9:0] !== 10'b1_0_11110100) begin miscompares++; $display("FAIL enable_frame: got %b expected 1011110100", got[9:0]); end
    wait_pulse(d0, e0);
    vectors++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL enable_result: got done=%0d err=%0d expected done=1 err=0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_nack;
    logic [10:0] got; int inh; logic pd, sb;
    int d0 = done_cnt, e0 = err_cnt;
    send(8'h55, 1'b1, 11, got, inh, pd, sb);
    vectors++; if (got[9:0] !== 10'b1_1_01010101) begin miscompares++; $display("FAIL nack_frame: got %b expected 1101010101", got[9:0]); end
    wait_pulse(d0, e0);
    vectors++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin miscompares++; $display("FAIL nack_result: got done=%0d err=%0d expected done=0 err=1", done_cnt - d0, err_cnt - e0); end
    vectors++; if (pulse_ready !== 1'b1 || pulse_busy !== 1'b0) begin miscompares++; $display("FAIL nack_pulse: got ready=%b busy=%b expected ready=1 busy=0", pulse_ready, pulse_busy); end
    vectors++; if ({clk_dl, data_dl} !== 2'b00) begin miscompares++; $display("FAIL nack_drive: got %b expected 00", {clk_dl, data_dl}); end
  endtask

  task automatic test_timeout;
    logic [10:0] got; int inh; logic pd, sb;
    int d0 = done_cnt, e0 = err_cnt;
    send(CMD_SET_LEDS, 1'b0, 4, got, inh, pd, sb);
    vectors++; if (got[3:0] !== 4'b1101) begin miscompares++; $display("FAIL timeout_bits: got %b expected 1101", got[3:0]); end
    wait_pulse(d0, e0);
    vectors++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin miscompares++; $display("FAIL timeout_result: got done=%0d err=%0d expected done=0 err=1", done_cnt - d0, err_cnt - e0); end
    vectors++; if (err_cyc - last_fall < TMO || err_cyc - last_fall > TMO + SYNC + 2) begin miscompares++; $display("FAIL timeout_delay: got %0d expected %0d..%0d", err_cyc - last_fall, TMO, TMO + SYNC + 2); end
    vectors++; if ({busy, clk_dl, data_dl} !== 3'b000) begin miscompares++; $display("FAIL timeout_drive: got %b expected 000", {busy, clk_dl, data_dl}); end
  endtask

  task automatic test_reset_mid;
    logic [10:0] got; int inh; logic pd, sb;
    int d0, e0;
    send(CMD_ENABLE, 1'b0, 6, got, inh, pd, sb);
    vectors++; if (data_dl !== 1'b0) begin miscompares++; $display("FAIL mid_bit5: got %b expected 0", data_dl); end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if ({clk_dl, data_dl, tx_ready, busy} !== 4'b0010) begin miscompares++; $display("FAIL mid_reset: got %b expected 0010", {clk_dl, data_dl, tx_ready, busy}); end
    rst_n = 1'b1;
    @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    send(CMD_RESET, 1'b0, 11, got, inh, pd, sb);
    vectors++; if (got[9:0] !== 10'b1_1_11111111) begin miscompares++; $display("FAIL mid_ff_frame: got %b expected 1111111111", got[9:0]); end
    wait_pulse(d0, e0);
    vectors++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL mid_ff_result: got done=%0d err=%0d expected done=1 err=0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] got1, got2; int inh; logic pd, sb;
    int d0 = done_cnt, e0 = err_cnt;
    fork
      begin tx_valid = 1'b1; tx_data = CMD_SET_LEDS; @(negedge clk); tx_data = 8'h00; end
      device(1'b0, 11, got1, inh, pd, sb);
    join
    vectors++; if (got1[9:0] !== 10'b1_1_11101101) begin miscompares++; $display("FAIL b2b_first: got %b expected 1111101101", got1[9:0]); end
    fork
      begin wait_pulse(d0, e0); tx_valid = 1'b0; end
      device(1'b0, 11, got2, inh, pd, sb);
    join
    vectors++; if (got2[9:0] !== 10'b1_1_00000000) begin miscompares++; $display("FAIL b2b_second: got %b expected 1100000000", got2[9:0]); end
    vectors++; if (inh !== INH) begin miscompares++; $display("FAIL b2b_inhibit: got %0d expected %0d", inh, INH); end
    wait_pulse(d0 + 1, e0);
    vectors++; if (done_cnt - d0 !== 2 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL b2b_result: got done=%0d err=%0d expected done=2 err=0", done_cnt - d0, err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_set_leds();
    test_enable();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
